// File: rtl/uart_pkg.sv
// Shared UART definitions: baud defaults, 8N1 frame constants and the
// receiver state encodings, so transmitter and receiver agree on one baud.
package uart_pkg;

  // Default bit period is CLKCOUNTER+1 clocks; the counter must be wide
  // enough to hold CLKCOUNTER.
  localparam int CLKCOUNTER_DEF    = 8;
  localparam int NBITS_COUNTER_DEF = 8;

  // 8N1 frame.
  localparam int   DATA_BITS  = 8;
  localparam int   IDX_W      = $clog2(DATA_BITS);
  localparam logic STOP_LEVEL = 1'b1;

  // Receiver state encodings.
  localparam logic [2:0] ENC_IDLE      = 3'd0;
  localparam logic [2:0] ENC_START     = 3'd1;
  localparam logic [2:0] ENC_DATA      = 3'd2;
  localparam logic [2:0] ENC_STOP      = 3'd3;
  localparam logic [2:0] ENC_DONE      = 3'd4;
  localparam logic [2:0] ENC_ERR       = 3'd5;
  localparam logic [2:0] ENC_WAIT_HIGH = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE      = ENC_IDLE,
    S_START     = ENC_START,
    S_DATA      = ENC_DATA,
    S_STOP      = ENC_STOP,
    S_DONE      = ENC_DONE,
    S_ERR       = ENC_ERR,
    S_WAIT_HIGH = ENC_WAIT_HIGH
  } rx_state_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input. The reset
// value is a parameter so idle-high lines come out of reset idle.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  // Metastability filter: first flop may go metastable, second settles it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      // NOTE: non-blocking assignments make both flops sample the old values,
      // giving a true two-stage chain rather than a single flop.
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver. Detects the start edge on the synchronized line,
// confirms the start bit at mid-bit, then samples each data bit and the
// stop bit one full bit period apart. A good frame updates dataRX with a
// one-cycle dataValid strobe; a low stop bit gives a one-cycle frameError
// and the receiver then waits for the line to return high.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKCOUNTER    = CLKCOUNTER_DEF,   // >= 3
  parameter int NBITS_COUNTER = NBITS_COUNTER_DEF // 2**NBITS_COUNTER > CLKCOUNTER
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bitRX,
  output logic [DATA_BITS-1:0] dataRX,
  output logic                 dataValid,
  output logic                 frameError,
  output logic                 busy
);

  localparam logic [NBITS_COUNTER-1:0] C_FULL   = NBITS_COUNTER'(CLKCOUNTER);
  localparam logic [NBITS_COUNTER-1:0] C_HALF   = NBITS_COUNTER'(CLKCOUNTER / 2);
  localparam logic [IDX_W-1:0]         LAST_IDX = IDX_W'(DATA_BITS - 1);

  logic                     w_rxs;
  logic                     r_rxs_d;
  rx_state_t                r_state;
  logic [NBITS_COUNTER-1:0] r_cnt;
  logic [IDX_W-1:0]         r_idx;
  logic [DATA_BITS-1:0]     r_shift;
  logic [DATA_BITS-1:0]     r_data;
  logic                     r_valid;
  logic                     r_ferr;
  logic                     r_busy;

  uart_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk     (clk),
    .rst     (rst),
    .i_async (bitRX),
    .o_sync  (w_rxs)
  );

  // Delayed copy of the synchronized line for falling-edge detection.
  always_ff @(posedge clk) begin
    if (rst) r_rxs_d <= 1'b1;
    else     r_rxs_d <= w_rxs;
  end

  // Receive FSM with bit-period counter, bit index, shift register and
  // registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      // NOTE: strobes default low each cycle so they can only ever be
      // one-cycle pulses; every other register holds unless a branch writes it.
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;

      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (r_rxs_d && !w_rxs) begin
            r_state <= S_START;
            r_busy  <= 1'b1;
          end
        end

        S_START: begin
          if (r_cnt == C_HALF) begin
            r_cnt <= '0;
            if (!w_rxs) begin
              r_idx   <= '0;
              r_state <= S_DATA;
            end else begin
              // Line went back high before mid-bit: a glitch, not a start.
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_DATA: begin
          if (r_cnt == C_FULL) begin
            r_shift[r_idx] <= w_rxs;
            r_cnt          <= '0;
            r_idx          <= r_idx + 1'b1;
            if (r_idx == LAST_IDX) r_state <= S_STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_STOP: begin
          if (r_cnt == C_FULL) begin
            r_cnt  <= '0;
            r_busy <= 1'b0;
            if (w_rxs == STOP_LEVEL) begin
              r_data  <= r_shift;
              r_valid <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_ferr  <= 1'b1;
              r_state <= S_ERR;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_DONE: r_state <= S_IDLE;

        S_ERR: r_state <= S_WAIT_HIGH;

        // A held-low line (break) must not look like a string of start bits.
        S_WAIT_HIGH: begin
          if (w_rxs) r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign dataRX     = r_data;
  assign dataValid  = r_valid;
  assign frameError = r_ferr;
  assign busy       = r_busy;

endmodule
